gray_codec_pipe: RTL



---
 rtl/gray_codec_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready Gray-code engine: encode, decode, wrapping Gray increment, pass-through.
// S1 normalises the operand to binary where needed; S2 forms the result and holds it under backpressure.
module gray_codec_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_op,
  output logic             out_wrap
);

  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] gray_encode(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray_decode(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic             vld_p1;
  logic [1:0]       op_p1;
  logic [WIDTH-1:0] v_p1;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] v_in_p0;
  logic [WIDTH-1:0] inc_p1;
  logic [WIDTH-1:0] res_p1;
  logic             wrap_p1;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !vld_p1 || s2_adv;
  assign in_ready = s1_adv;

  // Stage 0 -> S1: decode Gray operands so S2 only ever works in binary
  always_comb begin
    v_in_p0 = in_data;
    if (in_op == OP_DEC || in_op == OP_INC) begin
      v_in_p0 = gray_decode(in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      op_p1  <= OP_ENC;
      v_p1   <= '0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
      op_p1  <= in_op;
      v_p1   <= v_in_p0;
    end
  end

  // S1 -> S2: form the result; increment carry-out is dropped, wrap flags all-ones input
  assign inc_p1 = v_p1 + ONE;

  always_comb begin
    res_p1  = v_p1;
    wrap_p1 = 1'b0;
    case (op_p1)
      OP_ENC:  res_p1 = gray_encode(v_p1);
      OP_DEC:  res_p1 = v_p1;
      OP_INC: begin
        res_p1  = gray_encode(inc_p1);
        wrap_p1 = &v_p1;
      end
      OP_PASS: res_p1 = v_p1;
      default: res_p1 = v_p1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= OP_ENC;
      out_wrap  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= res_p1;
        out_op   <= op_p1;
        out_wrap <= wrap_p1;
      end
    end
  end

endmodule
